uart_rx_fifo_param: RTL

//  Parametrised UART receiver, 8N1-compatible by default, for host/command links.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/sync_fifo.sv | 61 ++++++
 rtl/uart_rx_fifo_param.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types for the parametrised UART receiver: parity modes and receive FSM states.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  // True when the received parity bit disagrees with the accumulated data parity.
  function automatic logic parity_mismatch(input parity_t mode, input logic acc, input logic par_bit);
    logic odd_total;
    odd_total = acc ^ par_bit;
    return (mode == PAR_ODD) ? ~odd_total : odd_total;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with zero-latency head; a pop is honoured before a push so a full FIFO
// accepts a push in the same cycle it is popped.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Extra MSB on each pointer distinguishes full from empty when the indices match.
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign rdata = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    mem_d   = mem_q;
    if (do_push) begin
      mem_d[wptr_q[AW-1:0]] = wdata;
      wptr_d = wptr_q + PW'(1);
    end
    if (do_pop) begin
      rptr_d = rptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      mem_q  <= '{default: '0};
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      mem_q  <= mem_d;
    end
  end

endmodule

// File: rtl/uart_rx_fifo_param.sv
// UART receiver with synchroniser, false-start rejection, sticky error flags and receive FIFO.
// Data reaches rx_data one clk after the stop-bit sample; frames are dropped (ovr_err) when full.
module uart_rx_fifo_param
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 2604,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 RX,
  input  logic                 clr_rdy,
  input  logic                 err_clr,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rdy,
  output logic                 frm_err,
  output logic                 par_err,
  output logic                 ovr_err
);

  localparam int      CNT_W    = $clog2(CLK_DIV);
  localparam int      BIT_W    = $clog2(DATA_BITS + 1);
  localparam parity_t PAR_MODE = parity_t'(PARITY);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLK_DIV / 2);
  // A sample consumes the zero cycle, so reloading CLK_DIV-1 spaces samples CLK_DIV apart.
  localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLK_DIV - 1);

  rx_state_t            state_q, state_d;
  logic                 rx_meta_q, rx_meta_d;
  logic                 rx_s_q, rx_s_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_acc_q, par_acc_d;
  logic                 par_bad_q, par_bad_d;
  logic                 frm_err_q, frm_err_d;
  logic                 par_err_q, par_err_d;
  logic                 ovr_err_q, ovr_err_d;

  logic                 tick;
  logic                 push;
  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 frm_set;
  logic                 par_set;
  logic                 ovr_set;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (shift_q),
    .rdata (rx_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign rdy     = ~fifo_empty;
  assign pop     = clr_rdy & ~fifo_empty;
  assign frm_err = frm_err_q;
  assign par_err = par_err_q;
  assign ovr_err = ovr_err_q;

  always_comb begin
    rx_meta_d = RX;
    rx_s_d    = rx_meta_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_acc_d = par_acc_q;
    par_bad_d = par_bad_q;
    push      = 1'b0;
    frm_set   = 1'b0;
    par_set   = 1'b0;
    ovr_set   = 1'b0;
    tick      = (cnt_q == '0);

    if (state_q != IDLE && !tick) begin
      cnt_d = cnt_q - CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          cnt_d   = HALF_LOAD;
        end
      end
      START: begin
        if (tick) begin
          if (rx_s_q) begin
            state_d = IDLE;
          end else begin
            state_d   = DATA;
            cnt_d     = BIT_LOAD;
            bit_cnt_d = '0;
            par_acc_d = 1'b0;
            par_bad_d = 1'b0;
          end
        end
      end
      DATA: begin
        if (tick) begin
          shift_d   = {rx_s_q, shift_q[DATA_BITS-1:1]};
          par_acc_d = par_acc_q ^ rx_s_q;
          cnt_d     = BIT_LOAD;
          if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
            state_d = (PAR_MODE != PAR_NONE) ? uart_pkg::PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      uart_pkg::PARITY: begin
        if (tick) begin
          par_bad_d = parity_mismatch(PAR_MODE, par_acc_q, rx_s_q);
          cnt_d     = BIT_LOAD;
          state_d   = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          state_d = IDLE;
          if (!rx_s_q) begin
            frm_set = 1'b1;
          end else if (par_bad_q) begin
            par_set = 1'b1;
          end else if (fifo_full && !pop) begin
            ovr_set = 1'b1;
          end else begin
            push = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Setting wins over a same-cycle clear so no error event is ever lost.
    frm_err_d = err_clr ? 1'b0 : frm_err_q;
    par_err_d = err_clr ? 1'b0 : par_err_q;
    ovr_err_d = err_clr ? 1'b0 : ovr_err_q;
    if (frm_set) frm_err_d = 1'b1;
    if (par_set) par_err_d = 1'b1;
    if (ovr_set) ovr_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_acc_q <= 1'b0;
      par_bad_q <= 1'b0;
      frm_err_q <= 1'b0;
      par_err_q <= 1'b0;
      ovr_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rx_meta_q <= rx_meta_d;
      rx_s_q    <= rx_s_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_acc_q <= par_acc_d;
      par_bad_q <= par_bad_d;
      frm_err_q <= frm_err_d;
      par_err_q <= par_err_d;
      ovr_err_q <= ovr_err_d;
    end
  end

endmodule
